// File: rtl/frame_sequencer_if.sv
// Strobe/data/pulse bundle between the APU core (master) and the frame sequencer (slave).
interface frame_sequencer_if;
  logic       ACLK1;
  logic       W4017;
  logic       RD4015;
  logic [7:0] DB;
  logic       n_LFO1;
  logic       n_LFO2;
  logic       INT;

  modport master (
    output ACLK1, W4017, RD4015, DB,
    input  n_LFO1, n_LFO2, INT
  );

  modport slave (
    input  ACLK1, W4017, RD4015, DB,
    output n_LFO1, n_LFO2, INT
  );
endinterface

// File: rtl/frame_sequencer.sv
// APU frame sequencer: 4/5-step cycle counter driving quarter/half-frame pulses and the frame IRQ.
// Optional macro FRAME_SEQUENCER_FAST_EN shrinks the step points to 16/32/48/64/80 for short simulations.
module frame_sequencer (
  input  logic              CLK,
  input  logic              n_RES,
  frame_sequencer_if.slave  bus
);

`ifdef FRAME_SEQUENCER_FAST_EN
  localparam logic [14:0] S1 = 15'd16;
  localparam logic [14:0] S2 = 15'd32;
  localparam logic [14:0] S3 = 15'd48;
  localparam logic [14:0] S4 = 15'd64;
  localparam logic [14:0] S5 = 15'd80;
`else
  localparam logic [14:0] S1 = 15'd3728;
  localparam logic [14:0] S2 = 15'd7456;
  localparam logic [14:0] S3 = 15'd11185;
  localparam logic [14:0] S4 = 15'd14914;
  localparam logic [14:0] S5 = 15'd18640;
`endif

  logic [14:0] cnt_q,  cnt_d;
  logic        mode_q, mode_d;
  logic        inh_q,  inh_d;
  logic        irq_q,  irq_d;
  logic        pend_q, pend_d;
  logic        lfo1_q, lfo1_d;
  logic        lfo2_q, lfo2_d;

  logic        at_s1, at_s2, at_s3, at_s4, at_s5;
  logic        quarter_hit, half_hit, last_step;
  logic        cnt_reset, irq_set, irq_clr;
  logic        db_unused;

  assign db_unused = ^bus.DB[5:0];

  // S4 only counts as a step in 4-step mode, S5 only in 5-step mode
  assign at_s1 = (cnt_q == S1);
  assign at_s2 = (cnt_q == S2);
  assign at_s3 = (cnt_q == S3);
  assign at_s4 = (cnt_q == S4) && !mode_q;
  assign at_s5 = (cnt_q == S5) &&  mode_q;

  assign quarter_hit = at_s1 || at_s2 || at_s3 || at_s4 || at_s5;
  assign half_hit    = at_s2 || at_s4 || at_s5;
  assign last_step   = at_s4 || at_s5;

  // A write on this very edge defers the pending reload to the next APU cycle
  assign cnt_reset = bus.ACLK1 && pend_q && !bus.W4017;
  assign irq_set   = bus.ACLK1 && !cnt_reset && at_s4 && !inh_q;
  assign irq_clr   = bus.RD4015 || (bus.W4017 && bus.DB[6]);

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    inh_d  = inh_q;
    pend_d = pend_q;
    lfo1_d = lfo1_q;
    lfo2_d = lfo2_q;
    irq_d  = irq_q;

    if (cnt_reset) begin
      cnt_d  = 15'd0;
      pend_d = 1'b0;
      lfo1_d = !mode_q;
      lfo2_d = !mode_q;
    end else if (bus.ACLK1) begin
      cnt_d  = last_step ? 15'd0 : cnt_q + 15'd1;
      lfo1_d = !quarter_hit;
      lfo2_d = !half_hit;
    end

    if (bus.W4017) begin
      mode_d = bus.DB[7];
      inh_d  = bus.DB[6];
      pend_d = 1'b1;
    end

    if (irq_set)
      irq_d = 1'b1;
    else if (irq_clr)
      irq_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      cnt_q  <= 15'd0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
      lfo1_q <= 1'b1;
      lfo2_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
      lfo1_q <= lfo1_d;
      lfo2_q <= lfo2_d;
    end
  end

  assign bus.n_LFO1 = lfo1_q;
  assign bus.n_LFO2 = lfo2_q;
  assign bus.INT    = irq_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer in the default (full step point) build.
module tb_frame_sequencer;
  logic CLK = 1'b0;
  logic n_RES;

  frame_sequencer_if bus();

  frame_sequencer dut (
    .CLK   (CLK),
    .n_RES (n_RES),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         n;
    logic       aclk;
    logic       w;
    logic [7:0] db;
    logic       rd;
    logic       e_lfo1;
    logic       e_lfo2;
    logic       e_int;
    int         e_cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int passed = 0;

  function automatic void add(int n, logic aclk, logic w, logic [7:0] db, logic rd,
                              logic e1, logic e2, logic ei, int ec);
    vec_t v;
    v.n = n; v.aclk = aclk; v.w = w; v.db = db; v.rd = rd;
    v.e_lfo1 = e1; v.e_lfo2 = e2; v.e_int = ei; v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(int n, logic aclk, logic w, logic [7:0] db, logic rd);
    bus.ACLK1  = aclk;
    bus.W4017  = w;
    bus.DB     = db;
    bus.RD4015 = rd;
    repeat (n) @(posedge CLK);
    #1;
    bus.ACLK1  = 1'b0;
    bus.W4017  = 1'b0;
    bus.RD4015 = 1'b0;
  endtask

  task automatic check_all(string tag, logic e1, logic e2, logic ei, int ec);
    chk({tag, ".n_LFO1"}, int'(bus.n_LFO1), int'(e1));
    chk({tag, ".n_LFO2"}, int'(bus.n_LFO2), int'(e2));
    chk({tag, ".INT"},    int'(bus.INT),    int'(ei));
    chk({tag, ".CNT"},    int'(dut.cnt_q),  ec);
  endtask

  initial begin
    n_RES = 1'b0;
    bus.ACLK1 = 1'b0; bus.W4017 = 1'b0; bus.RD4015 = 1'b0; bus.DB = 8'h00;

    // 4-step run, IRQ set coincident with a status read
    add(3728,  1, 0, 8'h00, 0, 1, 1, 0, 3728);
    add(1,     1, 0, 8'h00, 0, 0, 1, 0, 3729);
    add(1,     0, 0, 8'h00, 0, 0, 1, 0, 3729);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 3730);
    add(3726,  1, 0, 8'h00, 0, 1, 1, 0, 7456);
    add(1,     1, 0, 8'h00, 0, 0, 0, 0, 7457);
    add(3728,  1, 0, 8'h00, 0, 1, 1, 0, 11185);
    add(1,     1, 0, 8'h00, 0, 0, 1, 0, 11186);
    add(3728,  1, 0, 8'h00, 0, 1, 1, 0, 14914);
    add(1,     1, 0, 8'h00, 1, 0, 0, 1, 0);
    add(1,     1, 0, 8'h00, 0, 1, 1, 1, 1);
    add(1,     0, 0, 8'h00, 1, 1, 1, 0, 1);
    // 5-step mode write, immediate double pulse on reload
    add(1,     0, 1, 8'h80, 0, 1, 1, 0, 1);
    add(1,     1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(14913, 1, 0, 8'h00, 0, 1, 1, 0, 14914);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 14915);
    add(3725,  1, 0, 8'h00, 0, 1, 1, 0, 18640);
    add(1,     1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 1);
    // write coincident with ACLK1: increment now, reload on the next cycle
    add(1,     1, 1, 8'h00, 0, 1, 1, 0, 2);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 0);
    add(14914, 1, 0, 8'h00, 0, 1, 1, 0, 14914);
    add(1,     1, 0, 8'h00, 0, 0, 0, 1, 0);
    // inhibit write clears IRQ; second write overwrites mode, single reload
    add(1,     0, 1, 8'hC0, 0, 0, 0, 0, 0);
    add(1,     0, 1, 8'h40, 0, 0, 0, 0, 0);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 0);
    add(14914, 1, 0, 8'h00, 0, 1, 1, 0, 14914);
    add(1,     1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(1,     1, 0, 8'h00, 0, 1, 1, 0, 1);

    // reset state, with strobes active during reset
    drive(2, 1, 1, 8'hC0, 1);
    check_all("reset", 1, 1, 0, 0);
    n_RES = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].n, vecs[i].aclk, vecs[i].w, vecs[i].db, vecs[i].rd);
      check_all($sformatf("row%0d", i), vecs[i].e_lfo1, vecs[i].e_lfo2, vecs[i].e_int, vecs[i].e_cnt);
    end

    // reset aborts an in-progress pulse and overrides a same-edge write
    drive(14913, 1, 0, 8'h00, 0);
    drive(1, 1, 0, 8'h00, 0);
    check_all("pre_abort", 0, 0, 0, 0);
    n_RES = 1'b0;
    drive(1, 1, 1, 8'hC0, 1);
    check_all("abort", 1, 1, 0, 0);
    n_RES = 1'b1;

    // after reset: 4-step, IRQ enabled, no pending reload
    drive(3728, 1, 0, 8'h00, 0);
    check_all("post_rst_a", 1, 1, 0, 3728);
    drive(11186, 1, 0, 8'h00, 0);
    check_all("post_rst_b", 1, 1, 0, 14914);
    drive(1, 1, 0, 8'h00, 0);
    check_all("post_rst_c", 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
